// File: rtl/pixel_framebuffer_if.sv
// Shared types and the bundled pixel-in / clear / scanout signals of the colour framebuffer.
// The DUT side uses the slave modport; the pixel source and display side use master.
package pixel_framebuffer_pkg;

    typedef logic [11:0] color12_t;

    typedef struct packed {
        color12_t    color;
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } pix_entry_t;

endpackage

interface pixel_framebuffer_if;
    import pixel_framebuffer_pkg::*;

    logic        in_valid;
    color12_t    in_color;
    logic [15:0] in_x;
    logic [15:0] in_y;

    logic        clear_start;
    color12_t    clear_color;
    logic        clear_busy;

    logic        scan_start;
    logic        scan_busy;

    logic        out_valid;
    logic        out_ready;
    color12_t    out_color;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic        out_last;

    modport master (
        output in_valid, in_color, in_x, in_y,
        output clear_start, clear_color, scan_start, out_ready,
        input  clear_busy, scan_busy,
        input  out_valid, out_color, out_x, out_y, out_last
    );

    modport slave (
        input  in_valid, in_color, in_x, in_y,
        input  clear_start, clear_color, scan_start, out_ready,
        output clear_busy, scan_busy,
        output out_valid, out_color, out_x, out_y, out_last
    );

endinterface

// File: rtl/pixel_framebuffer.sv
// Colour framebuffer: pixel write port, hardware frame-clear engine, and raster
// scanout through a 2-entry credit-controlled output FIFO.
module pixel_framebuffer
    import pixel_framebuffer_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 160,
    parameter int unsigned FB_HEIGHT = 120
) (
    input  logic              clk,
    input  logic              rst,
    pixel_framebuffer_if.slave fb_io
);

    localparam int unsigned FB_DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned ADDR_W   = $clog2(FB_DEPTH);

    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;
    typedef enum logic [1:0] {SCAN_IDLE, SCAN_READ, SCAN_DRAIN} scan_state_e;

    clr_state_e        clr_state_q, clr_state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    color12_t          clr_color_q, clr_color_d;
    logic              clear_busy_q, clear_busy_d;

    scan_state_e       scan_state_q, scan_state_d;
    logic [15:0]       scan_x_q, scan_x_d;
    logic [15:0]       scan_y_q, scan_y_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic              scan_busy_q, scan_busy_d;

    logic              rd_vld_q;
    logic [15:0]       rd_x_q, rd_y_q;
    logic              rd_last_q;
    color12_t          rdata_q;

    pix_entry_t        head_q, head_d, tail_q, tail_d;
    logic              head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;

    logic              we_c, pix_ok_c, pop_c, rd_en_c, scan_at_end_c;
    logic [ADDR_W-1:0] waddr_c;
    color12_t          wdata_c;
    logic [1:0]        credit_use_c;
    pix_entry_t        push_entry_c;

    color12_t          mem [FB_DEPTH];

    // Clear engine state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_state_q  <= CLR_IDLE;
            clr_addr_q   <= '0;
            clr_color_q  <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            clr_state_q  <= clr_state_d;
            clr_addr_q   <= clr_addr_d;
            clr_color_q  <= clr_color_d;
            clear_busy_q <= clear_busy_d;
        end
    end

    always_comb begin
        clr_state_d = clr_state_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        case (clr_state_q)
            CLR_IDLE: begin
                if (fb_io.clear_start) begin
                    clr_state_d = CLR_RUN;
                    clr_addr_d  = '0;
                    clr_color_d = fb_io.clear_color;
                end
            end
            CLR_RUN: begin
                if (clr_addr_q == ADDR_W'(FB_DEPTH - 1)) clr_state_d = CLR_IDLE;
                else                                     clr_addr_d  = clr_addr_q + ADDR_W'(1);
            end
            default: clr_state_d = CLR_IDLE;
        endcase
        clear_busy_d = (clr_state_d == CLR_RUN);
    end

    // Single write port: the clear engine owns it while running, pixels are dropped meanwhile
    always_comb begin
        pix_ok_c = fb_io.in_valid && (fb_io.in_x < 16'(FB_WIDTH)) &&
                   (fb_io.in_y < 16'(FB_HEIGHT)) && !clear_busy_q;
        we_c     = 1'b0;
        waddr_c  = ADDR_W'(fb_io.in_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(fb_io.in_x);
        wdata_c  = fb_io.in_color;
        if (clr_state_q == CLR_RUN) begin
            we_c    = 1'b1;
            waddr_c = clr_addr_q;
            wdata_c = clr_color_q;
        end else if (pix_ok_c) begin
            we_c = 1'b1;
        end
    end

    // Storage is not reset; read-first falls out of non-blocking update order
    always_ff @(posedge clk) begin
        if (we_c)    mem[waddr_c] <= wdata_c;
        if (rd_en_c) rdata_q      <= mem[scan_addr_q];
    end

    // Scan engine state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_state_q <= SCAN_IDLE;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            scan_addr_q  <= '0;
            scan_busy_q  <= 1'b0;
        end else begin
            scan_state_q <= scan_state_d;
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
            scan_addr_q  <= scan_addr_d;
            scan_busy_q  <= scan_busy_d;
        end
    end

    // A slot freed by this cycle's pop counts as a credit, giving 1 pixel/cycle
    always_comb begin
        pop_c         = head_vld_q && fb_io.out_ready;
        credit_use_c  = 2'(head_vld_q) + 2'(tail_vld_q) + 2'(rd_vld_q) - 2'(pop_c);
        rd_en_c       = (scan_state_q == SCAN_READ) && (credit_use_c < 2'd2);
        scan_at_end_c = (scan_x_q == 16'(FB_WIDTH - 1)) && (scan_y_q == 16'(FB_HEIGHT - 1));

        scan_state_d = scan_state_q;
        scan_x_d     = scan_x_q;
        scan_y_d     = scan_y_q;
        scan_addr_d  = scan_addr_q;
        case (scan_state_q)
            SCAN_IDLE: begin
                if (fb_io.scan_start) begin
                    scan_state_d = SCAN_READ;
                    scan_x_d     = '0;
                    scan_y_d     = '0;
                    scan_addr_d  = '0;
                end
            end
            SCAN_READ: begin
                if (rd_en_c) begin
                    if (scan_at_end_c) begin
                        scan_state_d = SCAN_DRAIN;
                    end else begin
                        scan_addr_d = scan_addr_q + ADDR_W'(1);
                        if (scan_x_q == 16'(FB_WIDTH - 1)) begin
                            scan_x_d = '0;
                            scan_y_d = scan_y_q + 16'd1;
                        end else begin
                            scan_x_d = scan_x_q + 16'd1;
                        end
                    end
                end
            end
            SCAN_DRAIN: begin
                if (pop_c && head_q.last) scan_state_d = SCAN_IDLE;
            end
            default: scan_state_d = SCAN_IDLE;
        endcase
        scan_busy_d = (scan_state_d != SCAN_IDLE);
    end

    // Coordinates travel alongside the one-cycle RAM read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_x_q    <= '0;
            rd_y_q    <= '0;
            rd_last_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_en_c;
            if (rd_en_c) begin
                rd_x_q    <= scan_x_q;
                rd_y_q    <= scan_y_q;
                rd_last_q <= scan_at_end_c;
            end
        end
    end

    // Head/tail FIFO: head is the output register, only changes on pop or while empty
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        head_vld_d   = head_vld_q;
        tail_vld_d   = tail_vld_q;
        push_entry_c = '{color: rdata_q, x: rd_x_q, y: rd_y_q, last: rd_last_q};
        if (pop_c) begin
            head_d     = tail_q;
            head_vld_d = tail_vld_q;
            tail_vld_d = 1'b0;
        end
        if (rd_vld_q) begin
            if (!head_vld_d) begin
                head_d     = push_entry_c;
                head_vld_d = 1'b1;
            end else begin
                tail_d     = push_entry_c;
                tail_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
        end
    end

    assign fb_io.clear_busy = clear_busy_q;
    assign fb_io.scan_busy  = scan_busy_q;
    assign fb_io.out_valid  = head_vld_q;
    assign fb_io.out_color  = head_q.color;
    assign fb_io.out_x      = head_q.x;
    assign fb_io.out_y      = head_q.y;
    assign fb_io.out_last   = head_q.last;

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed bench for pixel_framebuffer: reset, write + aborted/full scan,
// clear engine with dropped writes, and a backpressured full-frame scan.
module tb_pixel_framebuffer;

    localparam int unsigned W = 160;
    localparam int unsigned H = 120;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    pixel_framebuffer_if fb_if ();

    pixel_framebuffer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
        .clk   (clk),
        .rst   (rst),
        .fb_io (fb_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        fb_if.in_valid    = 1'b0;
        fb_if.in_color    = '0;
        fb_if.in_x        = '0;
        fb_if.in_y        = '0;
        fb_if.clear_start = 1'b0;
        fb_if.clear_color = '0;
        fb_if.scan_start  = 1'b0;
        fb_if.out_ready   = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({fb_if.out_valid, fb_if.out_last, fb_if.clear_busy, fb_if.scan_busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {fb_if.out_valid, fb_if.out_last, fb_if.clear_busy, fb_if.scan_busy});
        end
        checks++;
        if ({fb_if.out_color, fb_if.out_x, fb_if.out_y} !== 44'h0) begin
            failures++;
            $display("FAIL reset_payload: got %h expected 0", {fb_if.out_color, fb_if.out_x, fb_if.out_y});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({fb_if.out_valid, fb_if.clear_busy, fb_if.scan_busy} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset: got %b expected 000",
                     {fb_if.out_valid, fb_if.clear_busy, fb_if.scan_busy});
        end
    endtask

    // Write (3,2), abort a scan at pixel 500 with reset, then run a full scan
    task automatic test_write_abort_rescan();
        int hs, cyc, ex, ey, first_valid, final_edge, order_err, last_err;
        logic [11:0] pix;

        fb_if.in_valid = 1'b1; fb_if.in_x = 16'd3; fb_if.in_y = 16'd2; fb_if.in_color = 12'hABC;
        tick();
        fb_if.in_valid  = 1'b0;
        fb_if.out_ready = 1'b1;
        fb_if.scan_start = 1'b1;
        tick();
        fb_if.scan_start = 1'b0;
        hs = 0; cyc = 0; ex = 0; ey = 0; order_err = 0; last_err = 0; pix = 12'h000;
        while (hs < 500 && cyc < 2000) begin
            if (fb_if.out_valid && fb_if.out_ready) begin
                if (fb_if.out_x !== 16'(ex) || fb_if.out_y !== 16'(ey)) order_err++;
                if (fb_if.out_last !== 1'b0) last_err++;
                if (ex == 3 && ey == 2) pix = fb_if.out_color;
                hs++;
                if (ex == int'(W) - 1) begin ex = 0; ey++; end else ex++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (hs !== 500 || order_err !== 0 || last_err !== 0) begin
            failures++;
            $display("FAIL partial_scan: handshakes=%0d order_err=%0d last_err=%0d expected 500/0/0",
                     hs, order_err, last_err);
        end
        checks++;
        if (pix !== 12'hABC) begin
            failures++;
            $display("FAIL partial_pix_3_2: got %h expected abc", pix);
        end

        rst = 1'b1;
        #1;
        checks++;
        if ({fb_if.out_valid, fb_if.out_last, fb_if.scan_busy, fb_if.out_color, fb_if.out_x, fb_if.out_y} !== 47'h0) begin
            failures++;
            $display("FAIL abort_outputs: valid=%b last=%b busy=%b color=%h x=%0d y=%0d expected all 0",
                     fb_if.out_valid, fb_if.out_last, fb_if.scan_busy, fb_if.out_color, fb_if.out_x, fb_if.out_y);
        end
        tick();
        rst = 1'b0;
        tick();

        fb_if.scan_start = 1'b1;
        tick();
        fb_if.scan_start = 1'b0;
        hs = 0; cyc = 0; ex = 0; ey = 0; order_err = 0; last_err = 0;
        first_valid = -1; final_edge = -1; pix = 12'h000;
        while (hs < N && cyc < 25000) begin
            if (fb_if.out_valid && first_valid < 0) first_valid = cyc;
            fb_if.scan_start = (cyc == 100);
            if (fb_if.out_valid && fb_if.out_ready) begin
                if (fb_if.out_x !== 16'(ex) || fb_if.out_y !== 16'(ey)) order_err++;
                if (fb_if.out_last !== (ex == int'(W) - 1 && ey == int'(H) - 1)) last_err++;
                if (ex == 3 && ey == 2) pix = fb_if.out_color;
                hs++;
                if (hs == N) final_edge = cyc + 1;
                if (ex == int'(W) - 1) begin ex = 0; ey++; end else ex++;
            end
            tick();
            cyc++;
        end
        fb_if.scan_start = 1'b0;
        checks++;
        if (hs !== N) begin
            failures++;
            $display("FAIL full_scan_count: got %0d expected %0d", hs, N);
        end
        checks++;
        if (first_valid !== 2) begin
            failures++;
            $display("FAIL first_valid_latency: got %0d expected 2", first_valid);
        end
        checks++;
        if (final_edge !== N + 2) begin
            failures++;
            $display("FAIL frame_cycles: got %0d expected %0d", final_edge, N + 2);
        end
        checks++;
        if (order_err !== 0 || last_err !== 0) begin
            failures++;
            $display("FAIL full_scan_order: order_err=%0d last_err=%0d expected 0/0", order_err, last_err);
        end
        checks++;
        if (pix !== 12'hABC) begin
            failures++;
            $display("FAIL pix_3_2: got %h expected abc", pix);
        end
        checks++;
        if (fb_if.scan_busy !== 1'b0 || fb_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL scan_end_idle: busy=%b valid=%b expected 0/0", fb_if.scan_busy, fb_if.out_valid);
        end
    endtask

    // Clear to 0x0F0; restart attempt and an in-range write during the clear are ignored
    task automatic test_clear();
        int cyc;
        fb_if.clear_color = 12'h0F0;
        fb_if.clear_start = 1'b1;
        tick();
        fb_if.clear_start = 1'b0;
        fb_if.clear_color = 12'h000;
        checks++;
        if (fb_if.clear_busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_busy_rise: got %b expected 1", fb_if.clear_busy);
        end
        cyc = 0;
        fb_if.in_x = 16'd5; fb_if.in_y = 16'd5; fb_if.in_color = 12'h123;
        while (fb_if.clear_busy && cyc < 25000) begin
            fb_if.clear_start = (cyc == 10);
            fb_if.clear_color = (cyc == 10) ? 12'hF00 : 12'h000;
            fb_if.in_valid    = (cyc == 50);
            tick();
            cyc++;
        end
        fb_if.clear_start = 1'b0;
        fb_if.in_valid    = 1'b0;
        checks++;
        if (cyc !== N) begin
            failures++;
            $display("FAIL clear_busy_len: got %0d expected %0d", cyc, N);
        end

        // Out-of-range writes must vanish; (159,119) is the last in-range pixel
        fb_if.in_valid = 1'b1; fb_if.in_color = 12'hFFF;
        fb_if.in_x = 16'd160;    fb_if.in_y = 16'd0;    tick();
        fb_if.in_x = 16'd0;      fb_if.in_y = 16'd120;  tick();
        fb_if.in_x = 16'hFFFF;   fb_if.in_y = 16'hFFFF; tick();
        fb_if.in_x = 16'd159;    fb_if.in_y = 16'd119;  fb_if.in_color = 12'h7E7; tick();
        fb_if.in_valid = 1'b0;
    endtask

    task automatic test_backpressure_scan();
        int hs, cyc, ex, ey, order_err, color_err, last_err, stable_err, busy_err;
        logic [15:0] lfsr;
        logic [44:0] saved;
        logic        prev_stall, rdy;
        logic [11:0] exp_color;

        lfsr = 16'hACE1; prev_stall = 1'b0; saved = '0;
        hs = 0; cyc = 0; ex = 0; ey = 0;
        order_err = 0; color_err = 0; last_err = 0; stable_err = 0; busy_err = 0;
        fb_if.out_ready  = 1'b0;
        fb_if.scan_start = 1'b1;
        tick();
        fb_if.scan_start = 1'b0;
        while (hs < N && cyc < 45000) begin
            if (prev_stall && (!fb_if.out_valid ||
                {fb_if.out_color, fb_if.out_x, fb_if.out_y, fb_if.out_last} !== saved)) stable_err++;
            if (!fb_if.scan_busy) busy_err++;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            rdy  = (lfsr[1:0] != 2'b00) && !(cyc >= 1000 && cyc < 1015) && !(cyc >= 7000 && cyc < 7012);
            fb_if.out_ready = rdy;
            if (fb_if.out_valid && rdy) begin
                exp_color = (ex == int'(W) - 1 && ey == int'(H) - 1) ? 12'h7E7 : 12'h0F0;
                if (fb_if.out_x !== 16'(ex) || fb_if.out_y !== 16'(ey)) order_err++;
                if (fb_if.out_color !== exp_color) begin
                    if (color_err == 0)
                        $display("FAIL bp_first_bad_pixel: x=%0d y=%0d got %h expected %h",
                                 ex, ey, fb_if.out_color, exp_color);
                    color_err++;
                end
                if (fb_if.out_last !== (ex == int'(W) - 1 && ey == int'(H) - 1)) last_err++;
                hs++;
                if (ex == int'(W) - 1) begin ex = 0; ey++; end else ex++;
            end
            prev_stall = fb_if.out_valid && !rdy;
            saved      = {fb_if.out_color, fb_if.out_x, fb_if.out_y, fb_if.out_last};
            tick();
            cyc++;
        end
        fb_if.out_ready = 1'b1;
        checks++;
        if (hs !== N) begin
            failures++;
            $display("FAIL bp_count: got %0d expected %0d", hs, N);
        end
        checks++;
        if (order_err !== 0 || last_err !== 0) begin
            failures++;
            $display("FAIL bp_order: order_err=%0d last_err=%0d expected 0/0", order_err, last_err);
        end
        checks++;
        if (color_err !== 0) begin
            failures++;
            $display("FAIL bp_colors: bad pixels got %0d expected 0", color_err);
        end
        checks++;
        if (stable_err !== 0) begin
            failures++;
            $display("FAIL bp_stable: unstable stalls got %0d expected 0", stable_err);
        end
        checks++;
        if (busy_err !== 0 || fb_if.scan_busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_scan_busy: low_while_running=%0d final=%b expected 0/0", busy_err, fb_if.scan_busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_abort_rescan();
        test_clear();
        test_backpressure_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
